// File: rtl/seg_disp_pkg.sv
// Shared definitions for the BCD counter and its 7-segment display:
// nibble width, segment patterns (active-high, seg[0]=a .. seg[6]=g) and the decoder.
package seg_disp_pkg;

  localparam int unsigned BcdW = 4;

  localparam logic [6:0] Seg0     = 7'h3F;
  localparam logic [6:0] Seg1     = 7'h06;
  localparam logic [6:0] Seg2     = 7'h5B;
  localparam logic [6:0] Seg3     = 7'h4F;
  localparam logic [6:0] Seg4     = 7'h66;
  localparam logic [6:0] Seg5     = 7'h6D;
  localparam logic [6:0] Seg6     = 7'h7D;
  localparam logic [6:0] Seg7     = 7'h07;
  localparam logic [6:0] Seg8     = 7'h7F;
  localparam logic [6:0] Seg9     = 7'h6F;
  localparam logic [6:0] SegBlank = 7'h00;

  // Non-BCD nibbles cannot occur; they decode to blank rather than garbage.
  function automatic logic [6:0] seg_decode(input logic [BcdW-1:0] nib);
    logic [6:0] pat;
    case (nib)
      4'd0:    pat = Seg0;
      4'd1:    pat = Seg1;
      4'd2:    pat = Seg2;
      4'd3:    pat = Seg3;
      4'd4:    pat = Seg4;
      4'd5:    pat = Seg5;
      4'd6:    pat = Seg6;
      4'd7:    pat = Seg7;
      4'd8:    pat = Seg8;
      4'd9:    pat = Seg9;
      default: pat = SegBlank;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD digit of the up/down counter chain; step_out ripples carry/borrow
// combinationally to the next digit in the same cycle.
module bcd_digit
  import seg_disp_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            step_in,
  input  logic            up_dn,
  output logic [BcdW-1:0] digit,
  output logic            step_out
);

  logic [BcdW-1:0] digit_q, digit_d;
  logic            at_limit;

  always_comb begin
    at_limit = up_dn ? (digit_q == 4'd9) : (digit_q == 4'd0);
    step_out = step_in & at_limit;
    digit_d  = digit_q;
    if (clr) begin
      digit_d = '0;
    end else if (step_in) begin
      if (at_limit) digit_d = up_dn ? 4'd0 : 4'd9;
      else          digit_d = up_dn ? digit_q + 4'd1 : digit_q - 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) digit_q <= '0;
    else     digit_q <= digit_d;
  end

  assign digit = digit_q;

endmodule

// File: rtl/bcd_tick_counter_display.sv
// Counts rising edges of the divided clock level in BCD and scans the value
// onto a multiplexed 7-segment display.
module bcd_tick_counter_display
  import seg_disp_pkg::*;
#(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 100000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       div_clk_in,
  input  logic                       en,
  input  logic                       up_dn,
  input  logic                       clr,
  output logic [BcdW*NUM_DIGITS-1:0] count_bcd,
  output logic                       tick,
  output logic                       wrap,
  output logic [6:0]                 seg,
  output logic                       dp,
  output logic [NUM_DIGITS-1:0]      an
);

  localparam int unsigned ScanW = $clog2(SCAN_DIV);
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic        Inv   = SEG_ACTIVE_LOW;

  logic                  prev_q;
  logic                  edge_det;
  logic                  advance;
  logic [NUM_DIGITS:0]   step;
  logic [ScanW-1:0]      scan_cnt_q, scan_cnt_d;
  logic [IdxW-1:0]       dig_idx_q, dig_idx_d;
  logic [BcdW-1:0]       sel_nib;
  logic [NUM_DIGITS-1:0] an_act;

  assign edge_det = div_clk_in & ~prev_q;
  // clr takes priority, so a coincident edge must not ripple into the digits.
  assign advance  = edge_det & en & ~clr;
  assign step[0]  = advance;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : gen_digit
    bcd_digit u_digit (
      .clk      (clk),
      .rst      (rst),
      .clr      (clr),
      .step_in  (step[g]),
      .up_dn    (up_dn),
      .digit    (count_bcd[g*BcdW +: BcdW]),
      .step_out (step[g+1])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
      tick   <= 1'b0;
      wrap   <= 1'b0;
    end else begin
      prev_q <= div_clk_in;
      tick   <= advance;
      wrap   <= step[NUM_DIGITS];
    end
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + ScanW'(1);
    dig_idx_d  = dig_idx_q;
    if (scan_cnt_q == ScanW'(SCAN_DIV - 1)) begin
      scan_cnt_d = '0;
      dig_idx_d  = (dig_idx_q == IdxW'(NUM_DIGITS - 1)) ? '0 : dig_idx_q + IdxW'(1);
    end
  end

  always_comb begin
    sel_nib = '0;
    an_act  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (dig_idx_q == IdxW'(i)) begin
        sel_nib   = count_bcd[i*BcdW +: BcdW];
        an_act[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scan_cnt_q <= '0;
      dig_idx_q  <= '0;
      an         <= {NUM_DIGITS{Inv}};
      seg        <= {7{Inv}};
      dp         <= Inv;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      dig_idx_q  <= dig_idx_d;
      an         <= Inv ? ~an_act : an_act;
      seg        <= Inv ? ~seg_decode(sel_nib) : seg_decode(sel_nib);
      dp         <= Inv;
    end
  end

endmodule

// File: tb/tb_bcd_tick_counter_display.sv
// Scoreboard bench: the driver models the counter as an integer mod 10^4 and the
// display as a time-indexed digit scan; a monitor pops and compares each cycle.
module tb_bcd_tick_counter_display;

  localparam int ND = 4;
  localparam int SD = 4;
  localparam int M  = 10000;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          div_clk_in = 1'b0;
  logic          en = 1'b0;
  logic          up_dn = 1'b1;
  logic          clr = 1'b0;
  logic [15:0]   count_bcd;
  logic          tick, wrap, dp;
  logic [6:0]    seg;
  logic [3:0]    an;

  bcd_tick_counter_display #(
    .NUM_DIGITS     (ND),
    .SCAN_DIV       (SD),
    .SEG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .div_clk_in (div_clk_in),
    .en         (en),
    .up_dn      (up_dn),
    .clr        (clr),
    .count_bcd  (count_bcd),
    .tick       (tick),
    .wrap       (wrap),
    .seg        (seg),
    .dp         (dp),
    .an         (an)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [15:0] cnt;
    logic        tick;
    logic        wrap;
    logic [3:0]  an;
    logic [6:0]  seg;
  } exp_t;

  exp_t       sbq[$];
  int         checks = 0;
  int         errors = 0;
  int         cnt = 0;
  bit         prev = 1'b0;
  int         k = 0;
  logic [6:0] pat [10] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07, 7'h7F, 7'h6F};

  function automatic int pow10(input int n);
    int r = 1;
    for (int i = 0; i < n; i++) r = r * 10;
    return r;
  endfunction

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    for (int i = 0; i < ND; i++) r[i*4 +: 4] = 4'((v / pow10(i)) % 10);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // One clock cycle of stimulus; called at a falling edge.
  task automatic step(input bit d, input bit e, input bit u, input bit c);
    exp_t x;
    int   idx;
    bit   edg;
    div_clk_in = d; en = e; up_dn = u; clr = c;
    k++;
    idx = ((k - 1) / SD) % ND;
    x.an  = ~(4'b0001 << idx);
    x.seg = ~pat[(cnt / pow10(idx)) % 10];
    edg  = d && !prev;
    prev = d;
    x.tick = 1'b0;
    x.wrap = 1'b0;
    if (c) begin
      cnt = 0;
    end else if (edg && e) begin
      x.tick = 1'b1;
      if (u) begin
        x.wrap = (cnt == M - 1);
        cnt    = (cnt + 1) % M;
      end else begin
        x.wrap = (cnt == 0);
        cnt    = (cnt + M - 1) % M;
      end
    end
    x.cnt = to_bcd(cnt);
    sbq.push_back(x);
    @(negedge clk);
  endtask

  task automatic pulses(input int n, input bit e, input bit u);
    repeat (n) begin
      step(1'b1, e, u, 1'b0);
      step(1'b0, e, u, 1'b0);
    end
  endtask

  // Asynchronous reset: outputs must be inactive right away, before any clock edge.
  task automatic do_reset();
    div_clk_in = 1'b0; en = 1'b0; up_dn = 1'b1; clr = 1'b0;
    rst = 1'b1;
    #1;
    check("rst_count", 32'(count_bcd), 32'h0);
    check("rst_tick", 32'(tick), 32'h0);
    check("rst_wrap", 32'(wrap), 32'h0);
    check("rst_an", 32'(an), 32'hF);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_dp", 32'(dp), 32'h1);
    sbq.delete();
    cnt = 0; prev = 1'b0; k = 0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sbq.size() > 0) begin
        e = sbq.pop_front();
        check("count_bcd", 32'(count_bcd), 32'(e.cnt));
        check("tick", 32'(tick), 32'(e.tick));
        check("wrap", 32'(wrap), 32'(e.wrap));
        check("an", 32'(an), 32'(e.an));
        check("seg", 32'(seg), 32'(e.seg));
        check("dp", 32'(dp), 32'h1);
      end
    end
  end

  initial begin : driver
    @(negedge clk);
    do_reset();

    // Count to 0123, then reset mid-count.
    pulses(123, 1'b1, 1'b1);
    do_reset();

    // Twelve edges up; falling edges must do nothing.
    pulses(12, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);

    // Down wrap to 9999, up wrap to 0000, down wrap again.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    pulses(1, 1'b1, 1'b0);
    pulses(1, 1'b1, 1'b1);
    pulses(1, 1'b1, 1'b0);

    // Clear coincident with an edge at 0457, then edges with en low.
    step(1'b0, 1'b1, 1'b1, 1'b1);
    pulses(457, 1'b1, 1'b1);
    step(1'b1, 1'b1, 1'b1, 1'b1);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    pulses(3, 1'b0, 1'b1);

    // Hold 1234 while the display scans through all digits.
    pulses(1234, 1'b1, 1'b1);
    repeat (20) step(1'b0, 1'b0, 1'b1, 1'b0);

    // en raised while the level is already high: no advance until the next rise.
    step(1'b1, 1'b0, 1'b1, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b1, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b1, 1'b0);

    // Randomized traffic with one reset in the middle.
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      step(1'($urandom_range(0, 1)), ($urandom % 4) != 0, 1'($urandom % 2),
           ($urandom % 32) == 0);
    end

    step(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
